spi_att_data_gen: RTL and testbench

Upstream feeder for the SPI attenuator controller. Holds per-device attenuation codes written from the register bus in a shadow bank. On change, periodic refresh or software force, it commits them into a packed, stable DATA vector and issues a start pulse to the SPI engine. It then tracks the transfer through the engine's busy flag, with timeout and error reporting.

---
 rtl/spi_att_pkg.sv | 31 +++
 rtl/att_refresh_timer.sv | 32 +++
 rtl/level_sync.sv | 28 ++
 rtl/spi_att_data_gen.sv | 182 ++++++++++++++++++
 tb/tb_spi_att_data_gen.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_att_pkg.sv
// Shared types and constants for the SPI attenuator data path.
`default_nettype none

package spi_att_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LATCH     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  localparam int                      DEF_N_DEV        = 8;
  localparam int                      DEF_ATT_BITS     = 6;
  localparam logic [DEF_ATT_BITS-1:0] DEF_INIT_CODE    = 6'h3F;
  localparam int                      DEF_BUSY_TIMEOUT = 1024;

  // Width of the frame handed to the SPI controller.
  function automatic int n_bits(input int n_dev, input int att_bits);
    return n_dev * att_bits;
  endfunction

  // LSB of device k; device 0 sits in the MSBs so it is shifted first.
  function automatic int dev_lsb(input int k, input int n_dev, input int att_bits);
    return (n_dev - 1 - k) * att_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/att_refresh_timer.sv
// Free-running counter producing a one-cycle tick every PERIOD cycles; PERIOD = 0 disables the tick.
`default_nettype none

module att_refresh_timer #(
  parameter int PERIOD = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(PERIOD - 1));
  assign tick = (PERIOD != 0) && wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/level_sync.sv
// Two-flop level synchroniser with asynchronous clear.
`default_nettype none

module level_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_att_data_gen.sv
// Shadow bank of attenuator codes; commits them into a stable packed frame and
// sequences the SPI engine through start / busy with timeout reporting.
`default_nettype none

module spi_att_data_gen
  import spi_att_pkg::*;
#(
  parameter int                  N_DEV          = DEF_N_DEV,
  parameter int                  ATT_BITS       = DEF_ATT_BITS,
  parameter int                  ADDR_BITS      = 5,
  parameter logic [ATT_BITS-1:0] INIT_CODE      = DEF_INIT_CODE,
  parameter bit                  INVERT         = 1'b0,
  parameter int                  REFRESH_PERIOD = 0,
  parameter int                  BUSY_TIMEOUT   = DEF_BUSY_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [ADDR_BITS-1:0]      wr_addr,
  input  logic [ATT_BITS-1:0]       wr_data,
  input  logic                      force_req,
  input  logic [ADDR_BITS-1:0]      rd_addr,
  output logic [ATT_BITS-1:0]       rd_data,
  input  logic                      spi_busy,
  output logic                      spi_start,
  output logic [N_DEV*ATT_BITS-1:0] DATA,
  output logic                      pending,
  output logic                      err,
  output logic [15:0]               update_cnt
);

  localparam int NB = n_bits(N_DEV, ATT_BITS);
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  logic                rst_n;
  logic                refresh_tick;
  logic [ATT_BITS-1:0] shadow [N_DEV];
  logic [NB-1:0]       shadow_packed;
  logic [NB-1:0]       active;
  logic [ATT_BITS-1:0] rd_next;
  logic                dirty;
  logic                refresh_due;
  logic                force_due;
  logic                wr_hit;
  logic [TW-1:0]       tmo_cnt;
  state_t              state;
  state_t              state_nxt;
  logic                latch_en;
  logic                start_pulse;
  logic                timeout_hit;
  logic                frame_done;

  // Reset asserts asynchronously but is released in step with clk.
  level_sync #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_rst_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (1'b1),
    .q     (rst_n)
  );

  att_refresh_timer #(
    .PERIOD (REFRESH_PERIOD)
  ) u_refresh (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (refresh_tick)
  );

  assign wr_hit  = wr_en && ({1'b0, wr_addr} < (ADDR_BITS + 1)'(N_DEV));
  assign pending = dirty | refresh_due | force_due;

  for (genvar k = 0; k < N_DEV; k++) begin : g_pack
    localparam int LSB = dev_lsb(k, N_DEV, ATT_BITS);
    assign shadow_packed[LSB +: ATT_BITS] = shadow[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_DEV; k++) shadow[k] <= INIT_CODE;
    end else if (wr_hit) begin
      for (int k = 0; k < N_DEV; k++) begin
        if (wr_addr == ADDR_BITS'(k)) shadow[k] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (rd_addr == ADDR_BITS'(k)) rd_next = shadow[k];
    end
  end

  // A request arriving in the LATCH cycle outranks the clear so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty       <= 1'b1;
      refresh_due <= 1'b0;
      force_due   <= 1'b0;
    end else begin
      if (wr_hit || timeout_hit) dirty <= 1'b1;
      else if (latch_en)         dirty <= 1'b0;

      if (refresh_tick)  refresh_due <= 1'b1;
      else if (latch_en) refresh_due <= 1'b0;

      if (force_req)     force_due <= 1'b1;
      else if (latch_en) force_due <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    latch_en    = 1'b0;
    start_pulse = 1'b0;
    timeout_hit = 1'b0;
    frame_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        latch_en  = 1'b1;
        state_nxt = ST_START;
      end
      ST_START: begin
        start_pulse = 1'b1;
        state_nxt   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (spi_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!spi_busy) begin
          frame_done = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign spi_start = start_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= {N_DEV{INIT_CODE}};
      tmo_cnt    <= '0;
      err        <= 1'b0;
      update_cnt <= '0;
      rd_data    <= '0;
    end else begin
      rd_data <= rd_next;
      if (latch_en) active <= shadow_packed;
      if (start_pulse)                 tmo_cnt <= '0;
      else if (state == ST_WAIT_BUSY)  tmo_cnt <= tmo_cnt + TW'(1);
      if (timeout_hit) err <= 1'b1;
      if (frame_done)  update_cnt <= update_cnt + 16'd1;
    end
  end

  assign DATA = INVERT ? ~active : active;

endmodule

`default_nettype wire

// File: tb/tb_spi_att_data_gen.sv
// Directed bench with a frame scoreboard for spi_att_data_gen.
`default_nettype none

module tb_spi_att_data_gen;

  localparam int N_DEV = 8;
  localparam int ATT   = 6;
  localparam int AB    = 5;
  localparam int NB    = N_DEV * ATT;
  localparam int TMO   = 1024;
  localparam int RPER  = 100;
  localparam logic [NB-1:0] ALL_INIT = {N_DEV{6'h3F}};

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [AB-1:0] wr_addr;
  logic [ATT-1:0] wr_data;
  logic          force_req;
  logic [AB-1:0] rd_addr;
  logic [ATT-1:0] rd_data;
  logic          spi_busy;
  logic          spi_start;
  logic [NB-1:0] data;
  logic          pending;
  logic          err;
  logic [15:0]   update_cnt;

  logic           busy_r;
  logic           start_r;
  logic [NB-1:0]  data_r;
  logic           pending_r;
  logic           err_r;
  logic [15:0]    cnt_r;
  logic [ATT-1:0] rd_data_r;
  logic           zero1 = 1'b0;
  logic [AB-1:0]  zero_a = '0;
  logic [ATT-1:0] zero_d = '0;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          start_cnt = 0;
  int unsigned last_start_cyc = 0;
  logic        busy_en = 1'b1;
  logic [NB-1:0]  exp_q[$];
  int unsigned    r_times[$];
  logic [ATT-1:0] m_shadow [N_DEV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_att_data_gen #(
    .N_DEV(N_DEV), .ATT_BITS(ATT), .ADDR_BITS(AB), .INIT_CODE(6'h3F),
    .INVERT(1'b0), .REFRESH_PERIOD(0), .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .force_req(force_req), .rd_addr(rd_addr), .rd_data(rd_data), .spi_busy(spi_busy),
    .spi_start(spi_start), .DATA(data), .pending(pending), .err(err), .update_cnt(update_cnt)
  );

  spi_att_data_gen #(
    .N_DEV(N_DEV), .ATT_BITS(ATT), .ADDR_BITS(AB), .INIT_CODE(6'h3F),
    .INVERT(1'b0), .REFRESH_PERIOD(RPER), .BUSY_TIMEOUT(TMO)
  ) dut_r (
    .clk(clk), .reset_n(reset_n), .wr_en(zero1), .wr_addr(zero_a), .wr_data(zero_d),
    .force_req(zero1), .rd_addr(zero_a), .rd_data(rd_data_r), .spi_busy(busy_r),
    .spi_start(start_r), .DATA(data_r), .pending(pending_r), .err(err_r), .update_cnt(cnt_r)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] pack_model();
    logic [NB-1:0] v = '0;
    for (int k = 0; k < N_DEV; k++) v[NB-1-ATT*k -: ATT] = m_shadow[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AB-1:0] a, input logic [ATT-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (update_cnt !== 16'(target) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cnt"}, 64'(update_cnt), 64'(target));
    check({tag, "_pending"}, 64'(pending), 64'd0);
    check({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  // Scoreboard: every start must match the oldest expected frame.
  initial begin
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        start_cnt++;
        last_start_cyc = cyc;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL start_unexpected: observed start=1 expected start=0");
        end
        if (exp_q.size() != 0) check("frame_data", 64'(data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    spi_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1 && busy_en) begin
        repeat ($urandom_range(2, 8)) @(posedge clk);
        #1 spi_busy = 1'b1;
        repeat ($urandom_range(2, 20)) @(posedge clk);
        #1 spi_busy = 1'b0;
      end
    end
  end

  initial begin
    busy_r = 1'b0;
    forever begin
      @(negedge clk);
      if (start_r === 1'b1) begin
        r_times.push_back(cyc);
        check("refresh_data", 64'(data_r), 64'(ALL_INIT));
        repeat (3) @(posedge clk);
        #1 busy_r = 1'b1;
        repeat (10) @(posedge clk);
        #1 busy_r = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [NB-1:0] fr;
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; force_req = 1'b0; rd_addr = '0;
    for (int k = 0; k < N_DEV; k++) m_shadow[k] = 6'h3F;
    repeat (3) tick();

    check("rst_start", 64'(spi_start), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cnt", 64'(update_cnt), 64'd0);
    check("rst_rd", 64'(rd_data), 64'd0);
    check("rst_data", 64'(data), 64'(ALL_INIT));
    check("rst_pending", 64'(pending), 64'd1);

    exp_q.push_back(pack_model());
    reset_n = 1'b1;
    n = 0;
    while (spi_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("init_start_latency", 64'(n), 64'd5);
    wait_frames(1, "init");

    n = start_cnt;
    write(5'd0, 6'h01);
    write(5'd7, 6'h2A);
    m_shadow[0] = 6'h01; m_shadow[7] = 6'h2A;
    exp_q.push_back(pack_model());
    wait_frames(2, "wr2");
    check("wr2_one_start", 64'(start_cnt), 64'(n + 1));
    fr = data;
    check("wr2_dev0", 64'(fr[47:42]), 64'h01);
    check("wr2_dev7", 64'(fr[5:0]), 64'h2A);
    rd_addr = 5'd7; tick();
    check("rd_dev7", 64'(rd_data), 64'h2A);
    rd_addr = 5'd0; tick();
    check("rd_dev0", 64'(rd_data), 64'h01);
    rd_addr = 5'd9; tick();
    check("rd_oob", 64'(rd_data), 64'd0);

    exp_q.push_back(pack_model());
    force_req = 1'b1; tick(); force_req = 1'b0;
    wait_frames(3, "force");

    write(5'd1, 6'h15);
    m_shadow[1] = 6'h15;
    exp_q.push_back(pack_model());
    tick();
    write(5'd2, 6'h33);
    m_shadow[2] = 6'h33;
    exp_q.push_back(pack_model());
    wait_frames(5, "latch_race");

    busy_en = 1'b0;
    write(5'd3, 6'h0C);
    m_shadow[3] = 6'h0C;
    exp_q.push_back(pack_model());
    n = 0;
    while (spi_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("tmo_start", 64'(spi_start), 64'd1);
    repeat (1000) @(negedge clk);
    check("tmo_err_early", 64'(err), 64'd0);
    n = 0;
    while (err !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_cycles", 64'(cyc - last_start_cyc), 64'(TMO + 1));
    exp_q.push_back(pack_model());
    busy_en = 1'b1;
    wait_frames(6, "retry");
    check("err_sticky", 64'(err), 64'd1);

    check("refresh_starts", 64'(r_times.size() >= 5), 64'd1);
    for (int i = 1; i < 5 && i < r_times.size(); i++)
      check("refresh_interval", 64'(r_times[i] - r_times[i-1]), 64'(RPER));
    check("refresh_err", 64'(err_r), 64'd0);

    n = start_cnt;
    write(5'd9, 6'h11);
    repeat (10) tick();
    check("oob_no_start", 64'(start_cnt), 64'(n));
    check("oob_pending", 64'(pending), 64'd0);
    rd_addr = 5'd1; tick();
    check("oob_shadow", 64'(rd_data), 64'h15);

    write(5'd4, 6'h20);
    m_shadow[4] = 6'h20;
    exp_q.push_back(pack_model());
    n = 0;
    while (spi_busy !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    check("mid_busy", 64'(spi_busy), 64'd1);
    @(posedge clk); #2;
    check("mid_cnt", 64'(update_cnt), 64'd6);
    reset_n = 1'b0;
    #1;
    check("async_start", 64'(spi_start), 64'd0);
    check("async_err", 64'(err), 64'd0);
    check("async_cnt", 64'(update_cnt), 64'd0);
    check("async_data", 64'(data), 64'(ALL_INIT));
    check("async_pending", 64'(pending), 64'd1);
    check("async_rd", 64'(rd_data), 64'd0);
    n = 0;
    while (spi_busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("mid_queue", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k < N_DEV; k++) m_shadow[k] = 6'h3F;
    exp_q.push_back(pack_model());
    tick();
    reset_n = 1'b1;
    wait_frames(1, "post_rst");
    rd_addr = 5'd4; tick();
    check("post_rst_rd", 64'(rd_data), 64'h3F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
